// File: rtl/counter_param_saturating_pkg.sv
// Shared constants and per-edge action decode for the saturating counter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package counter_param_saturating_pkg;

`include "counter_defs.vh"

    localparam int DEF_WIDTH    = `CPS_DEF_WIDTH;
    localparam int DEF_MAX_VAL  = `CPS_DEF_MAX_VAL;
    localparam int DEF_MIN_VAL  = `CPS_DEF_MIN_VAL;
    localparam int DEF_WRAP     = `CPS_DEF_WRAP;
    localparam int DEF_TICK_DIV = `CPS_DEF_TICK_DIV;

    localparam logic DIR_UP = `CPS_DIR_UP;
    localparam logic DIR_DN = `CPS_DIR_DN;

    // What the count register does on a given edge (reset handled separately)
    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_STEP  = 2'd1,
        ACT_LOAD  = 2'd2,
        ACT_CLEAR = 2'd3
    } act_e;

    // Control inputs seen on one edge, bundled for the decoder
    typedef struct packed {
        logic clear;
        logic load;
        logic tick;
    } ctrl_t;

    // Priority: clear > load > step > hold
    function automatic act_e pick_act(input ctrl_t c);
        act_e a;
        if (c.clear) begin
            a = ACT_CLEAR;
        end else if (c.load) begin
            a = ACT_LOAD;
        end else if (c.tick) begin
            a = ACT_STEP;
        end else begin
            a = ACT_HOLD;
        end
        return a;
    endfunction

endpackage

// File: rtl/counter_defs.vh
`ifndef COUNTER_DEFS_VH
`define COUNTER_DEFS_VH

// Default parameter values for counter_param_saturating
`define CPS_DEF_WIDTH    3
`define CPS_DEF_MAX_VAL  7
`define CPS_DEF_MIN_VAL  0
`define CPS_DEF_WRAP     0
`define CPS_DEF_TICK_DIV 1

// Direction encodings on the dir port
`define CPS_DIR_UP 1'b1
`define CPS_DIR_DN 1'b0

`endif

// File: rtl/tick_prescaler.sv
// Divides enabled clocks by TICK_DIV and flags the edge on which a count step happens.
// Latency: tick is combinational from the current prescale state and en.
// Backpressure: none; en low freezes the prescale state, zero restarts the period.
module tick_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic zero,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] phase;

    // Step is issued on the enabled edge where the phase sits at its last value
    assign tick = en && (phase == LAST);

    // Phase advances only while enabled and wraps back to 0 after the step edge
    always_ff @(posedge clk) begin
        if (rst || zero) begin
            phase <= '0;
        end else if (en) begin
            if (phase == LAST) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_param_saturating.sv
// Up/down counter between MIN_VAL and MAX_VAL that saturates or wraps, with prescaled stepping.
// Latency: one clock from the qualifying edge to count and done; at_max/at_min follow count combinationally.
// Backpressure: none; en low holds count and freezes the prescaler.
module counter_param_saturating
    import counter_param_saturating_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_VAL  = DEF_MAX_VAL,
    parameter int MIN_VAL  = DEF_MIN_VAL,
    parameter int WRAP     = DEF_WRAP,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             done
);

    // Reject illegal parameter combinations while elaborating
    if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL) begin : g_bad_range
        $error("counter_param_saturating: need 0 <= MIN_VAL < MAX_VAL");
    end
    if (WIDTH < 1 || WIDTH > 31 || MAX_VAL > ((2 ** WIDTH) - 1)) begin : g_bad_width
        $error("counter_param_saturating: MAX_VAL must fit in WIDTH bits (WIDTH 1..31)");
    end
    if (TICK_DIV < 1) begin : g_bad_div
        $error("counter_param_saturating: TICK_DIV must be at least 1");
    end

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_M1 = WIDTH'(MAX_VAL - 1);
    localparam logic [WIDTH-1:0] MIN_P1 = WIDTH'(MIN_VAL + 1);
    localparam logic             WRAP_EN = (WRAP != 0);

    logic             tick;
    logic             pre_zero;
    ctrl_t            ctrl;
    act_e             act;
    logic [WIDTH-1:0] step_val;
    logic             step_done;
    logic [WIDTH-1:0] load_clamped;

    // clear and load both restart the prescale period
    assign pre_zero = clear || load;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .zero (pre_zero),
        .tick (tick)
    );

    assign ctrl = '{clear: clear, load: load, tick: tick};
    assign act  = pick_act(ctrl);

    assign at_max = (count == MAX_V);
    assign at_min = (count == MIN_V);

    // Next value for a step; done only when landing on the travel terminal or wrapping
    always_comb begin
        step_val  = count;
        step_done = 1'b0;
        if (dir == DIR_UP) begin
            if (count == MAX_V) begin
                if (WRAP_EN) begin
                    step_val  = MIN_V;
                    step_done = 1'b1;
                end
            end else begin
                step_val  = count + 1'b1;
                step_done = (count == MAX_M1);
            end
        end else begin
            if (count == MIN_V) begin
                if (WRAP_EN) begin
                    step_val  = MAX_V;
                    step_done = 1'b1;
                end
            end else begin
                step_val  = count - 1'b1;
                step_done = (count == MIN_P1);
            end
        end
    end

    // Loaded values are forced into the legal range
    always_comb begin
        if (load_val > MAX_V) begin
            load_clamped = MAX_V;
        end else if (load_val < MIN_V) begin
            load_clamped = MIN_V;
        end else begin
            load_clamped = load_val;
        end
    end

    // Count and done registers; reset beats every other action
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= MIN_V;
            done  <= 1'b0;
        end else begin
            case (act)
                ACT_CLEAR: begin
                    count <= MIN_V;
                    done  <= 1'b0;
                end
                ACT_LOAD: begin
                    count <= load_clamped;
                    done  <= 1'b0;
                end
                ACT_STEP: begin
                    count <= step_val;
                    done  <= step_done;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_param_saturating.sv
// Directed bench for counter_param_saturating: four parameterisations share stimulus,
// expectations are queued at drive time and checked by a separate monitor after each edge.
module tb_counter_param_saturating;

    logic       clk;
    logic       rst, en, dir, clear, load;
    logic [3:0] lv;

    logic [2:0] c0, c1, c3;
    logic [3:0] c2;
    logic       mx0, mn0, d0, mx1, mn1, d1, mx2, mn2, d2, mx3, mn3, d3;

    typedef struct {
        int    unit;
        int    cnt;
        bit    dn;
        string name;
    } exp_t;

    exp_t sbq[$];
    int   n_chk;
    int   n_fail;
    int   umin[4] = '{0, 0, 2, 0};
    int   umax[4] = '{7, 7, 9, 7};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Defaults
    counter_param_saturating u_def (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .clear(clear), .load(load),
        .load_val(lv[2:0]), .count(c0), .at_max(mx0), .at_min(mn0), .done(d0)
    );

    // Wrapping
    counter_param_saturating #(.WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .clear(clear), .load(load),
        .load_val(lv[2:0]), .count(c1), .at_max(mx1), .at_min(mn1), .done(d1)
    );

    // Wider, non-zero minimum, clamping on load
    counter_param_saturating #(.WIDTH(4), .MAX_VAL(9), .MIN_VAL(2)) u_w4 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .clear(clear), .load(load),
        .load_val(lv), .count(c2), .at_max(mx2), .at_min(mn2), .done(d2)
    );

    // Prescaled by 3
    counter_param_saturating #(.TICK_DIV(3)) u_div (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .clear(clear), .load(load),
        .load_val(lv[2:0]), .count(c3), .at_max(mx3), .at_min(mn3), .done(d3)
    );

    task automatic drive(input int unit, input bit r, input bit e, input bit d,
                         input bit c, input bit l, input int v,
                         input int ecnt, input bit edn, input string nm);
        exp_t x;
        @(negedge clk);
        rst   = r;
        en    = e;
        dir   = d;
        clear = c;
        load  = l;
        lv    = v[3:0];
        x.unit = unit;
        x.cnt  = ecnt;
        x.dn   = edn;
        x.name = nm;
        sbq.push_back(x);
    endtask

    // Monitor: after every rising edge, check the oldest outstanding expectation
    initial begin
        exp_t x;
        int   acnt;
        bit   adn, amx, amn, emx, emn;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                case (x.unit)
                    0:       begin acnt = int'(c0); adn = d0; amx = mx0; amn = mn0; end
                    1:       begin acnt = int'(c1); adn = d1; amx = mx1; amn = mn1; end
                    2:       begin acnt = int'(c2); adn = d2; amx = mx2; amn = mn2; end
                    default: begin acnt = int'(c3); adn = d3; amx = mx3; amn = mn3; end
                endcase
                emx = (x.cnt == umax[x.unit]);
                emn = (x.cnt == umin[x.unit]);
                n_chk++;
                if (acnt != x.cnt) begin
                    n_fail++;
                    $display("FAIL %s count: got %0d want %0d", x.name, acnt, x.cnt);
                end
                n_chk++;
                if (adn != x.dn) begin
                    n_fail++;
                    $display("FAIL %s done: got %0d want %0d", x.name, adn, x.dn);
                end
                n_chk++;
                if (amx != emx || amn != emn) begin
                    n_fail++;
                    $display("FAIL %s flags: got max=%0d min=%0d want max=%0d min=%0d",
                             x.name, amx, amn, emx, emn);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks outstanding", sbq.size());
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int div_exp[11] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3};
        bit div_en[11]  = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1; en = 1'b0; dir = 1'b1; clear = 1'b0; load = 1'b0; lv = 4'd0;

        // Defaults: reset then count up and saturate at 7
        drive(0, 1, 0, 1, 0, 0, 0, 0, 0, "def_rst");
        for (int i = 1; i <= 10; i++) begin
            drive(0, 0, 1, 1, 0, 0, 0, (i < 7) ? i : 7, (i == 7), "def_up");
        end

        // Wrap up through 7 -> 0, and wrap down from 0 -> 7
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0, "wrap_rst");
        drive(1, 0, 0, 1, 0, 1, 6, 6, 0, "wrap_load6");
        drive(1, 0, 1, 1, 0, 0, 0, 7, 1, "wrap_up7");
        drive(1, 0, 1, 1, 0, 0, 0, 0, 1, "wrap_to0");
        drive(1, 0, 1, 1, 0, 0, 0, 1, 0, "wrap_up1");
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0, "wrap_load0");
        drive(1, 0, 1, 0, 0, 0, 0, 7, 1, "wrap_dn7");

        // Count down from 2 and saturate at 0
        drive(0, 0, 0, 0, 0, 1, 2, 2, 0, "dn_load2");
        drive(0, 0, 1, 0, 0, 0, 0, 1, 0, "dn_1");
        drive(0, 0, 1, 0, 0, 0, 0, 0, 1, "dn_0");
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, "dn_hold0");

        // Load clamping with MIN_VAL=2, MAX_VAL=9
        drive(2, 1, 0, 1, 0, 0, 0, 2, 0, "w4_rst");
        drive(2, 0, 0, 1, 0, 1, 12, 9, 0, "w4_load12");
        drive(2, 0, 0, 1, 0, 1, 0, 2, 0, "w4_load0");
        drive(2, 0, 0, 1, 0, 1, 8, 8, 0, "w4_load8");
        drive(2, 0, 1, 1, 0, 0, 0, 9, 1, "w4_up9");
        drive(2, 0, 1, 1, 0, 0, 0, 9, 0, "w4_sat9");

        // Prescaler by 3, with two disabled cycles mid-period
        drive(3, 1, 0, 1, 0, 0, 0, 0, 0, "div_rst");
        for (int i = 0; i < 11; i++) begin
            drive(3, 0, div_en[i], 1, 0, 0, 0, div_exp[i], 0, "div_step");
        end

        // Priority rst > clear > load > step
        drive(0, 0, 0, 1, 0, 1, 5, 5, 0, "prio_load5");
        drive(0, 1, 0, 1, 1, 1, 3, 0, 0, "prio_rst");
        drive(0, 0, 0, 1, 1, 1, 3, 0, 0, "prio_clr");
        drive(0, 0, 1, 1, 0, 1, 3, 3, 0, "prio_load");

        // Reset while about to step onto 7: no done afterwards
        drive(0, 0, 0, 1, 0, 1, 6, 6, 0, "rstmid_load6");
        drive(0, 1, 1, 1, 0, 0, 0, 0, 0, "rstmid_rst");
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0, "rstmid_after");

        // Clear beats a step onto the terminal
        drive(0, 0, 0, 1, 0, 1, 6, 6, 0, "clr_load6");
        drive(0, 0, 1, 1, 1, 0, 0, 0, 0, "clr_vs_step");
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0, "clr_after");

        repeat (3) @(negedge clk);
        n_chk++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d outstanding want 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
